// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - parametrised universal shift register with autonomous burst engine
//
// Optional feature macro: UNIV_SHIFT_REG_ROTATE_EN (adds rot input; rotate instead of serial fill)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   mode   in   2  manual op in IDLE: 00 hold, 01 shift left, 10 shift right, 11 load
//   si     in   1  serial in for left shift (enters q[0])
//   sir    in   1  serial in for right shift (enters q[WIDTH-1])
//   pi     in   WIDTH parallel load data
//   start  in   1  burst request, sampled in IDLE only
//   dir    in   1  burst direction, 0 left / 1 right, captured with start
//   len    in   LEN_W burst shift count, saturated to WIDTH, captured with start
//   rot    in   1  (macro only) rotate instead of using si/sir, captured with start for bursts
//   q      out  WIDTH register contents
//   so     out  1  q[WIDTH-1]
//   sor    out  1  q[0]
//   busy   out  1  high while in the SHIFT state
//   done   out  1  one-cycle completion pulse
module univ_shift_reg #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0,
    localparam int                LEN_W   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             si,
    input  logic             sir,
    input  logic [WIDTH-1:0] pi,
    input  logic             start,
    input  logic             dir,
    input  logic [LEN_W-1:0] len,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             sor,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [LEN_W-1:0] cnt_q;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;

    logic [LEN_W-1:0] len_sat;
    logic             fill_l;
    logic             fill_r;
    logic [WIDTH-1:0] shl_d;
    logic [WIDTH-1:0] shr_d;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    logic rot_q;
    logic rot_eff;

    // Manual shifts and the burst start edge see live rot; the rest of the burst uses the captured value.
    assign rot_eff = (state_q == SHIFT) ? rot_q : rot;
`endif

    always_comb begin
        len_sat = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        fill_l = rot_eff ? q_q[WIDTH-1] : si;
        fill_r = rot_eff ? q_q[0]       : sir;
`else
        fill_l = si;
        fill_r = sir;
`endif
        shl_d = {q_q[WIDTH-2:0], fill_l};
        shr_d = {fill_r, q_q[WIDTH-1:1]};
    end

    // cnt_q holds the number of shifts still owed after the current edge; the first
    // shift happens on the start edge, so a burst of N spends N-1 cycles in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= RST_VAL;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dir_q <= dir;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
                        rot_q <= rot;
`endif
                        if (len_sat == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            q_q <= dir ? shr_d : shl_d;
                            if (len_sat == LEN_W'(1)) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= SHIFT;
                                busy_q  <= 1'b1;
                                cnt_q   <= len_sat - LEN_W'(1);
                            end
                        end
                    end else begin
                        case (mode)
                            2'b01:   q_q <= shl_d;
                            2'b10:   q_q <= shr_d;
                            2'b11:   q_q <= pi;
                            default: q_q <= q_q;
                        endcase
                    end
                end
                SHIFT: begin
                    q_q   <= dir_q ? shr_d : shl_d;
                    cnt_q <= cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign q    = q_q;
    assign so   = q_q[WIDTH-1];
    assign sor  = q_q[0];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg (WIDTH=4, RST_VAL=1010)
module tb_univ_shift_reg;

    localparam int WIDTH = 4;
    localparam int LEN_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             si;
    logic             sir;
    logic [WIDTH-1:0] pi;
    logic             start;
    logic             dir;
    logic [LEN_W-1:0] len;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] q;
    logic             so;
    logic             sor;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    univ_shift_reg #(.WIDTH(WIDTH), .RST_VAL(4'b1010)) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .si    (si),
        .sir   (sir),
        .pi    (pi),
        .start (start),
        .dir   (dir),
        .len   (len),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .rot   (rot),
`endif
        .q     (q),
        .so    (so),
        .sor   (sor),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs until done is seen (bounded), counting busy cycles along the way.
    task automatic wait_done(output int nbusy, output logic seen);
        nbusy = 0;
        seen  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            tick();
        end
    endtask

    logic [WIDTH-1:0] ref_q;
    logic             hist [0:19];
    int               nb;
    logic             seen;

    initial begin
        rst = 1'b1; mode = 2'b00; si = 1'b0; sir = 1'b0; pi = '0;
        start = 1'b0; dir = 1'b0; len = '0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        rot = 1'b0;
`endif
        tick();
        tick();
        chk("reset_q", q, 4'b1010);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_so", so, 1'b1);
        chk("reset_sor", sor, 1'b0);

        // Serial-in/serial-out compatibility from a cleared register
        rst = 1'b0; mode = 2'b11; pi = 4'b0000;
        tick();
        chk("clear_q", q, 4'b0000);
        ref_q = 4'b0000;
        mode = 2'b01;
        for (int i = 0; i < 20; i++) begin
            si = 1'($urandom_range(1, 0));
            hist[i] = si;
            ref_q = {ref_q[2:0], si};
            tick();
            chk("siso_q", q, ref_q);
            if (i >= 3) chk("siso_so_delay", so, hist[i-3]);
        end

        // Load then shift right with sir=1
        mode = 2'b11; pi = 4'b1001;
        tick();
        chk("load_q", q, 4'b1001);
        mode = 2'b10; sir = 1'b1;
        tick();
        chk("shr1_q", q, 4'b1100);
        tick();
        chk("shr2_q", q, 4'b1110);

        // Burst left len=3 while mode=11 tries to load 1111
        mode = 2'b11; pi = 4'b0001;
        tick();
        chk("preload_q", q, 4'b0001);
        pi = 4'b1111; start = 1'b1; dir = 1'b0; len = 3'd3; si = 1'b0;
        tick();
        start = 1'b0;
        chk("bl_c1_q", q, 4'b0010);
        chk("bl_c1_busy", busy, 1'b1);
        chk("bl_c1_done", done, 1'b0);
        tick();
        chk("bl_c2_q", q, 4'b0100);
        chk("bl_c2_busy", busy, 1'b1);
        chk("bl_c2_done", done, 1'b0);
        tick();
        chk("bl_done_q", q, 4'b1000);
        chk("bl_done_busy", busy, 1'b0);
        chk("bl_done_pulse", done, 1'b1);
        tick();
        chk("bl_after_q", q, 4'b1000);
        chk("bl_after_done", done, 1'b0);
        mode = 2'b00;

        // len=0: done the cycle after start, q untouched
        start = 1'b1; len = 3'd0;
        tick();
        start = 1'b0;
        chk("len0_done", done, 1'b1);
        chk("len0_busy", busy, 1'b0);
        chk("len0_q", q, 4'b1000);
        tick();
        chk("len0_done_clear", done, 1'b0);

        // len=7 saturates to 4 shifts: 0110 -> 1011 -> 1101 -> 1110 -> 1111
        mode = 2'b11; pi = 4'b0110;
        tick();
        mode = 2'b00;
        start = 1'b1; dir = 1'b1; sir = 1'b1; len = 3'd7;
        tick();
        start = 1'b0;
        wait_done(nb, seen);
        chk("sat_done_seen", seen, 1'b1);
        chk("sat_busy_cycles", nb, 3);
        chk("sat_q", q, 4'b1111);
        tick();

        // Reset in the middle of a burst abandons it without done
        mode = 2'b11; pi = 4'b0011;
        tick();
        mode = 2'b00;
        start = 1'b1; dir = 1'b0; len = 3'd4; si = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_c1_q", q, 4'b0111);
        tick();
        chk("mid_c2_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_q", q, 4'b1010);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        tick();
        chk("mid_post_done", done, 1'b0);
        chk("mid_post_q", q, 4'b1010);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
        // Rotating burst of a full WIDTH returns the original pattern
        mode = 2'b11; pi = 4'b1011;
        tick();
        mode = 2'b00;
        rot = 1'b1; si = 1'b0; start = 1'b1; dir = 1'b0; len = 3'd4;
        tick();
        start = 1'b0;
        chk("rot_c1_q", q, 4'b0111);
        wait_done(nb, seen);
        chk("rot_done_seen", seen, 1'b1);
        chk("rot_q", q, 4'b1011);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
